// File: rtl/compare_arbiter_if.sv
// Request/response bundle between two requesters and the compare arbiter.
// A transfer happens on a rising clk edge where valid and ready are both high; the
// source holds its payload while valid is high and ready is low.
interface compare_arbiter_if #(
    parameter int REG_SIZE = 32
);
    logic                req0_valid;
    logic                req1_valid;
    logic                req0_ready;
    logic                req1_ready;
    logic [REG_SIZE-1:0] req0_a;
    logic [REG_SIZE-1:0] req0_b;
    logic [REG_SIZE-1:0] req1_a;
    logic [REG_SIZE-1:0] req1_b;
    logic [1:0]          req0_op;
    logic [1:0]          req1_op;
    logic                req0_signed;
    logic                req1_signed;
    logic                rsp0_valid;
    logic                rsp1_valid;
    logic                rsp0_ready;
    logic                rsp1_ready;
    logic [REG_SIZE-1:0] rsp_result;
    logic [15:0]         done_count;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_op, req1_op, req0_signed, req1_signed, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, done_count
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_op, req1_op, req0_signed, req1_signed, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, done_count
    );
endinterface

// File: rtl/compare_arbiter.sv
// Two-requester arbiter feeding one shared comparator (SLT/SEQ/SNE); one operation
// in flight at a time, result held until the owning requester takes it.
module compare_arbiter #(
    parameter int REG_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    compare_arbiter_if.slave  bus,
    output logic              dbg_state
);
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t              state;
    logic                rr;
    logic                owner;
    logic                grant;
    logic                accept;
    logic                rsp_fire;
    logic                cmp_bit;
    logic [REG_SIZE-1:0] op_a;
    logic [REG_SIZE-1:0] op_b;
    logic [1:0]          op_sel;
    logic                op_sgn;
    logic [1:0]          rsp_valid_q;
    logic [REG_SIZE-1:0] rsp_result_q;
    logic [15:0]         done_count_q;

    // A lone valid requester wins outright; contention falls back to the pointer.
    always_comb begin
        grant = rr;
        if (bus.req0_valid != bus.req1_valid) grant = bus.req1_valid;
    end

    always_comb begin
        op_a   = grant ? bus.req1_a      : bus.req0_a;
        op_b   = grant ? bus.req1_b      : bus.req0_b;
        op_sel = grant ? bus.req1_op     : bus.req0_op;
        op_sgn = grant ? bus.req1_signed : bus.req0_signed;
    end

    always_comb begin
        cmp_bit = 1'b0;
        case (op_sel)
            2'b00:   cmp_bit = op_sgn ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
            2'b01:   cmp_bit = (op_a == op_b);
            2'b10:   cmp_bit = (op_a != op_b);
            default: cmp_bit = 1'b0;
        endcase
    end

    assign accept   = (state == IDLE) && (grant ? bus.req1_valid : bus.req0_valid);
    assign rsp_fire = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

    assign bus.req0_ready = (state == IDLE) && !grant;
    assign bus.req1_ready = (state == IDLE) &&  grant;
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp_result = rsp_result_q;
    assign bus.done_count = done_count_q;
    assign dbg_state      = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr           <= 1'b0;
            owner        <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            done_count_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rsp_result_q <= {{(REG_SIZE-1){1'b0}}, cmp_bit};
                        owner        <= grant;
                        rsp_valid_q  <= grant ? 2'b10 : 2'b01;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // Pointer moves only on completion so a stalled response keeps priority fixed.
                    if (rsp_fire) begin
                        rsp_valid_q <= 2'b00;
                        rr          <= ~owner;
                        if (done_count_q != 16'hFFFF) done_count_q <= done_count_q + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_compare_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;

  always #5 clk = ~clk;

  compare_arbiter_if #(.REG_SIZE(W)) bus ();

  compare_arbiter #(.REG_SIZE(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_last  = '0;
  logic         m_rr    = 1'b0;
  logic         m_owner = 1'b0;
  logic [15:0]  m_count = 16'd0;

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic sg,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      2'd0: r[0] = sg ? (int'(a) < int'(b)) : (a < b);
      2'd1: r[0] = (a == b);
      2'd2: r[0] = (a != b);
      default: r[0] = 1'b0;
    endcase
    return r;
  endfunction

  initial begin
    logic g;
    logic [W-1:0] r;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_last  = '0;
        m_rr    = 1'b0;
        m_owner = 1'b0;
        m_count = 16'd0;
      end else if (exp_q.size() == 0) begin
        if (bus.req0_valid || bus.req1_valid) begin
          g = (bus.req0_valid && bus.req1_valid) ? m_rr : bus.req1_valid;
          r = g ? ref_result(bus.req1_op, bus.req1_signed, bus.req1_a, bus.req1_b)
                : ref_result(bus.req0_op, bus.req0_signed, bus.req0_a, bus.req0_b);
          exp_q.push_back(r);
          m_last  = r;
          m_owner = g;
        end
      end else if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
        void'(exp_q.pop_front());
        m_rr = ~m_owner;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic busy;
    logic g;
    busy = (exp_q.size() != 0);
    g    = (bus.req0_valid != bus.req1_valid) ? bus.req1_valid : m_rr;
    check("cmp_req0_ready", W'(bus.req0_ready), W'(!busy && !g));
    check("cmp_req1_ready", W'(bus.req1_ready), W'(!busy && g));
    check("cmp_rsp0_valid", W'(bus.rsp0_valid), W'(busy && !m_owner));
    check("cmp_rsp1_valid", W'(bus.rsp1_valid), W'(busy && m_owner));
    check("cmp_rsp_result", bus.rsp_result, busy ? exp_q[0] : m_last);
    check("cmp_done_count", W'(bus.done_count), W'(m_count));
    check("cmp_state", W'(dbg_state), W'(busy));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.req0_op = 2'b00; bus.req1_op = 2'b00;
    bus.req0_signed = 1'b0; bus.req1_signed = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
  endtask

  task automatic set_req(input int n, input logic [1:0] op, input logic sg,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_signed = sg;
      bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_signed = sg;
      bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic random_inputs();
    logic [W-1:0] a;
    bus.req0_valid  = ($urandom_range(0, 2) != 0);
    bus.req1_valid  = ($urandom_range(0, 2) != 0);
    bus.req0_op     = 2'($urandom_range(0, 3));
    bus.req1_op     = 2'($urandom_range(0, 3));
    bus.req0_signed = 1'($urandom_range(0, 1));
    bus.req1_signed = 1'($urandom_range(0, 1));
    a = pick_operand();
    bus.req0_a = a;
    bus.req0_b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
    a = pick_operand();
    bus.req1_a = a;
    bus.req1_b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
    bus.rsp0_ready = ($urandom_range(0, 3) != 0);
    bus.rsp1_ready = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    idle_inputs();
    apply_reset();
    check("reset_rsp0_valid", W'(bus.rsp0_valid), 32'd0);
    check("reset_rsp1_valid", W'(bus.rsp1_valid), 32'd0);
    check("reset_rsp_result", bus.rsp_result, 32'd0);
    check("reset_done_count", W'(bus.done_count), 32'd0);

    // Signed vs unsigned SLT on -1 < 1
    set_req(0, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'd1);
    #1 check("slt_s_ready0", W'(bus.req0_ready), 32'd1);
    tick(); bus.req0_valid = 1'b0;
    #1 check("slt_s_rsp0_valid", W'(bus.rsp0_valid), 32'd1);
    check("slt_s_result", bus.rsp_result, 32'd1);
    check("slt_s_ready0_in_resp", W'(bus.req0_ready), 32'd0);
    tick();
    check("slt_s_done", W'(bus.done_count), 32'd1);
    set_req(0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd1);
    tick(); bus.req0_valid = 1'b0;
    #1 check("slt_u_result", bus.rsp_result, 32'd0);
    tick();

    // Contention after reset: requester 0 first, then requester 1
    apply_reset();
    set_req(0, 2'b01, 1'b0, 32'd5, 32'd5);
    set_req(1, 2'b10, 1'b0, 32'd5, 32'd6);
    #1 check("rr_ready0", W'(bus.req0_ready), 32'd1);
    check("rr_ready1", W'(bus.req1_ready), 32'd0);
    tick(); bus.req0_valid = 1'b0;
    #1 check("rr_first_rsp0", W'(bus.rsp0_valid), 32'd1);
    check("rr_first_result", bus.rsp_result, 32'd1);
    tick();
    check("rr_second_ready1", W'(bus.req1_ready), 32'd1);
    tick(); bus.req1_valid = 1'b0;
    #1 check("rr_second_rsp1", W'(bus.rsp1_valid), 32'd1);
    check("rr_second_result", bus.rsp_result, 32'd1);
    tick();
    check("rr_done_two", W'(bus.done_count), 32'd2);

    // Stalled response on requester 1 with requester 0 waiting
    bus.rsp1_ready = 1'b0;
    set_req(1, 2'b01, 1'b0, 32'd7, 32'd8);
    tick(); bus.req1_valid = 1'b0;
    set_req(0, 2'b00, 1'b0, 32'd1, 32'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_rsp1_valid", W'(bus.rsp1_valid), 32'd1);
      check("stall_result", bus.rsp_result, 32'd0);
      check("stall_ready0", W'(bus.req0_ready), 32'd0);
      check("stall_done", W'(bus.done_count), 32'd2);
      tick();
    end
    bus.rsp1_ready = 1'b1;
    bus.rsp0_ready = 1'b0;
    tick();
    check("stall_done_after", W'(bus.done_count), 32'd3);
    check("no_accept_in_handshake", W'(dbg_state), 32'd0);

    // Asynchronous reset while a response is pending
    tick(); bus.req0_valid = 1'b0;
    #1 check("arst_pre_rsp0", W'(bus.rsp0_valid), 32'd1);
    check("arst_pre_result", bus.rsp_result, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("arst_rsp0_valid", W'(bus.rsp0_valid), 32'd0);
    check("arst_result", bus.rsp_result, 32'd0);
    check("arst_done", W'(bus.done_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;

    // Reserved op yields zero after a one-valued result
    set_req(0, 2'b01, 1'b0, 32'd3, 32'd3);
    tick(); bus.req0_valid = 1'b0;
    #1 check("seq_equal_result", bus.rsp_result, 32'd1);
    tick();
    set_req(0, 2'b11, 1'b0, 32'd0, 32'd0);
    tick(); bus.req0_valid = 1'b0;
    #1 check("reserved_op_result", bus.rsp_result, 32'd0);
    tick();

    // Saturation: preload the counter just below the top
    force dut.done_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    #1 release dut.done_count_q;
    for (int k = 0; k < 2; k++) begin
      set_req(1, 2'b10, 1'b0, 32'd1, 32'd2);
      tick(); bus.req1_valid = 1'b0;
      tick();
      check("sat_done_count", W'(bus.done_count), 32'hFFFF);
    end

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst_n = 1'b1;
      random_inputs();
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
